vend_brew_arbiter: RTL and testbench
====================================

Name: vend_brew_arbiter

Overview:
Shares one coffee brewer between N_REQ independent coin-acceptor front-ends. A front-end raises its request once its coin total is paid.
- The arbiter grants the brewer round-robin.
- It drives the brewer-active output `coffee` for a fixed brew time.
- It then pulses a per-requester `done`.
- It sits between the vending front-end instances and the single brewer actuator.

Parameters:
N_REQ, 3, number of requesting front-ends (2..8)
BREW_CYCLES, 8, clock cycles `coffee` is held high per grant (>=1)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  reset, synchronous, active-low
req  input  N_REQ  per-front-end level request; held until matching gnt seen
abort  input  1  terminates the current brew (service/fault)
gnt  output  N_REQ  one-hot, 1-cycle pulse: brewer assigned to requester i
owner  output  $clog2(N_REQ)  index of current/last grantee
coffee  output  1  brewer active
done  output  N_REQ  one-hot, 1-cycle pulse: brew for requester i complete
aborted  output  1  1-cycle pulse: current brew was aborted
busy  output  1  state != IDLE

Behaviour:
- Reset (rstn=0 at a rising edge):
  - state=IDLE.
  - gnt=0, done=0, coffee=0, aborted=0, busy=0, owner=0, brew counter=0.
  - Round-robin pointer last=N_REQ-1, so index 0 has first priority.
- Reset mid-brew: same values at the next edge; no done, no aborted pulse.
- States: IDLE, BREW, DISPENSE. All outputs are registered.
- IDLE:
  - If req!=0 at an edge, pick the first set bit searching last+1, last+2, … mod N_REQ.
  - At that edge: state->BREW, gnt[pick]=1 for 1 cycle, owner=pick, last=pick, coffee=1, counter=BREW_CYCLES-1.
  - If req==0, stay in IDLE.
- BREW:
  - coffee=1.
  - Counter decrements each cycle.
  - At the edge where counter==0: state->DISPENSE, coffee=0, done[owner]=1 for 1 cycle.
  - coffee is therefore high for exactly BREW_CYCLES cycles.
- DISPENSE: one cycle, then always ->IDLE; done drops.
- Grant spacing: minimum BREW_CYCLES+2 cycles between successive gnt pulses under continuous contention.
- abort:
  - Sampled only in BREW. At that edge: state->IDLE, coffee=0, aborted=1 for 1 cycle, no done.
  - last keeps the aborted owner, so that requester loses its turn.
  - In IDLE or DISPENSE, abort is ignored.
- abort and counter==0 at the same edge: abort wins.
- Requester contract:
  - Deassert req the cycle after seeing gnt.
  - A req still high when the arbiter returns to IDLE counts as a new request.
  - req dropped before grant is a withdrawal; it produces no grant.
- req changes during BREW/DISPENSE are ignored until IDLE.
- Invariants:
  - gnt, done and aborted are never simultaneously nonzero.
  - gnt and done are each at most one-hot.
  - owner is stable from gnt until the next gnt.

Decomposition:
- Shared package vend_pkg:
  - state enum vend_state_e {IDLE, BREW, DISPENSE}
  - default constants VEND_N_REQ=3, VEND_BREW_CYCLES=8
- One sub-module, vend_rr_pick: combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: valid, one-hot pick, pick index.
  - Reusable by later shared-resource arbiters (milk frother, cup dispenser).

Test Plan:
1. Single requester (N_REQ=3, BREW_CYCLES=4). req=3'b010 sampled at edge E0 -> gnt=3'b010 and owner=1 after E0. coffee high for exactly 4 cycles. done=3'b010 for 1 cycle right after coffee falls. busy falls one cycle later.
2. Full contention. req=3'b111 held constantly after reset -> grant order 0,1,2,0. gnt pulses are exactly 6 cycles apart. done order matches grant order.
3. Rotation. After a grant to 2, req=3'b101 -> next grant is 0. After a grant to 0, req=3'b101 -> next grant is 2.
4. Abort. Assert abort on the 2nd cycle of BREW -> coffee=0 and aborted=1 next cycle, no done. A pending req=3'b011 after an abort of owner 0 -> next grant is 1.
5. abort coincident with the last brew cycle -> aborted=1, done stays 0. Also: abort while IDLE -> no output change.
6. Reset. rstn=0 for 1 cycle mid-BREW -> next cycle all outputs 0 and busy=0. Following req=3'b110 -> grant to 1 (pointer restored to N_REQ-1).

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared types and defaults for the vending shared-resource arbiters.
//   vend_state_e      : arbiter FSM state encoding (IDLE, BREW, DISPENSE)
//   VEND_N_REQ        : default number of requesting front-ends
//   VEND_BREW_CYCLES  : default brew length in clock cycles
//   vend_cnt_w()      : width of a down-counter holding 0..n-1 (never 0 bits)
package vend_pkg;

  localparam int VEND_N_REQ       = 3;
  localparam int VEND_BREW_CYCLES = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BREW     = 2'd1,
    DISPENSE = 2'd2
  } vend_state_e;

  function automatic int vend_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// vend_rr_pick: combinational round-robin picker.
//   req      [N-1:0]  : request vector
//   last     [IW-1:0] : index of the previous winner
//   valid             : at least one request is set
//   pick_oh  [N-1:0]  : one-hot winner (zero when !valid)
//   pick_idx [IW-1:0] : index of the winner (zero when !valid)
// The search starts at last+1 and wraps, so the previous winner has the
// lowest priority on the next round.
module vend_rr_pick
  import vend_pkg::*;
#(
  parameter int N  = VEND_N_REQ,
  parameter int IW = $clog2(VEND_N_REQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [N-1:0]  pick_oh,
  output logic [IW-1:0] pick_idx
);

  logic          found;
  int            j;
  logic [IW-1:0] idx;

  always_comb begin
    valid    = |req;
    pick_oh  = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = 0;
    idx      = '0;
    for (int i = 1; i <= N; i++) begin
      j = int'(last) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!found && req[idx]) begin
        found         = 1'b1;
        pick_oh[idx]  = 1'b1;
        pick_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/vend_brew_arbiter.sv
// vend_brew_arbiter: shares one coffee brewer between N_REQ front-ends.
//   clk, rstn : clock (rising edge), synchronous active-low reset
//   req       : per-front-end level request
//   abort     : terminate the current brew (only honoured while brewing)
//   gnt       : one-hot 1-cycle pulse, brewer assigned to requester i
//   owner     : index of current/last grantee
//   coffee    : brewer actuator, high for BREW_CYCLES cycles per grant
//   done      : one-hot 1-cycle pulse, brew for requester i complete
//   aborted   : 1-cycle pulse, current brew was aborted
//   busy      : arbiter not idle
//
// Handshake: req is a level held by the front-end until it sees its gnt
// pulse; it must drop req the cycle after gnt. Only IDLE looks at req, so a
// req still high when the arbiter returns to IDLE is a fresh request, and a
// req dropped before being granted is simply withdrawn.
//
// All outputs are registered. The FSM state is held in `state` (encoded with
// vend_state_e values) for observation.
module vend_brew_arbiter
  import vend_pkg::*;
#(
  parameter int N_REQ       = VEND_N_REQ,
  parameter int BREW_CYCLES = VEND_BREW_CYCLES
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req,
  input  logic                     abort,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     coffee,
  output logic [N_REQ-1:0]         done,
  output logic                     aborted,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = vend_cnt_w(BREW_CYCLES);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_BREW     = BREW;
  localparam logic [1:0] S_DISPENSE = DISPENSE;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    last;

  logic             pick_valid;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;

  vend_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req      (req),
    .last     (last),
    .valid    (pick_valid),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      last    <= IW'(N_REQ - 1);  // index 0 wins first after reset
      gnt     <= '0;
      done    <= '0;
      owner   <= '0;
      coffee  <= 1'b0;
      aborted <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      gnt     <= '0;
      done    <= '0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state  <= S_BREW;
            gnt    <= pick_oh;
            owner  <= pick_idx;
            last   <= pick_idx;
            coffee <= 1'b1;
            busy   <= 1'b1;
            cnt    <= CW'(BREW_CYCLES - 1);
          end
        end
        S_BREW: begin
          // abort takes priority over normal completion; last keeps the
          // aborted owner so that requester loses its turn.
          if (abort) begin
            state   <= S_IDLE;
            coffee  <= 1'b0;
            aborted <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
          end else if (cnt == '0) begin
            state       <= S_DISPENSE;
            coffee      <= 1'b0;
            done[owner] <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DISPENSE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          coffee <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_brew_arbiter.sv
module tb_vend_brew_arbiter;

  localparam int N  = 3;
  localparam int BC = 4;
  localparam int IW = $clog2(N);

  // clock / reset
  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  req = '0;
  logic          abort = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] owner;
  logic          coffee;
  logic [N-1:0]  done;
  logic          aborted;
  logic          busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vend_brew_arbiter #(.N_REQ(N), .BREW_CYCLES(BC)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .abort   (abort),
    .gnt     (gnt),
    .owner   (owner),
    .coffee  (coffee),
    .done    (done),
    .aborted (aborted),
    .busy    (busy)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [N-1:0]  exp_gnt_q[$];
  logic [N-1:0]  exp_done_q[$];
  logic [IW-1:0] exp_abort_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // monitor: pops expectations whenever a pulse output fires
  always @(negedge clk) begin
    if (rstn) begin
      chk("exclusive", 32'(((gnt != '0) ? 1 : 0) + ((done != '0) ? 1 : 0) + (aborted ? 1 : 0) <= 1), 32'd1);
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'd0);
        else begin
          logic [N-1:0] e;
          e = exp_gnt_q.pop_front();
          chk("gnt", 32'(gnt), 32'(e));
          chk("owner", 32'(owner), 32'(idx_of(e)));
        end
      end
      if (done != '0) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
        else begin
          logic [N-1:0] e;
          e = exp_done_q.pop_front();
          chk("done", 32'(done), 32'(e));
        end
      end
      if (aborted) begin
        if (exp_abort_q.size() == 0) chk("aborted_unexpected", 32'(aborted), 32'd0);
        else begin
          logic [IW-1:0] e;
          e = exp_abort_q.pop_front();
          chk("abort_owner", 32'(owner), 32'(e));
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    req = '0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_gnt(input string name);
    int n = 0;
    @(negedge clk);
    while (gnt == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (gnt == '0) timeout_fail(name);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout_fail("wait_idle");
  endtask

  // One complete grant/brew/done round with a single request pattern.
  task automatic run_one(input logic [N-1:0] r, input int exp_idx);
    int n = 0;
    exp_gnt_q.push_back(N'(1) << exp_idx);
    exp_done_q.push_back(N'(1) << exp_idx);
    req = r;
    wait_gnt("run_gnt");
    req = '0;
    while (coffee && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("coffee_len", 32'(n), 32'(BC));
    chk("busy_dispense", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("done_drop", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           exp_idx;
  } vec_t;

  vec_t tbl[8];
  int   t_g[4];

  initial begin
    tbl[0] = '{3'b010, 1};
    tbl[1] = '{3'b111, 2};
    tbl[2] = '{3'b101, 0};
    tbl[3] = '{3'b101, 2};
    tbl[4] = '{3'b011, 0};
    tbl[5] = '{3'b110, 1};
    tbl[6] = '{3'b100, 2};
    tbl[7] = '{3'b001, 0};

    // reset state, sampled while rstn is still low
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_coffee", 32'(coffee), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // table: single requesters and round-robin rotation
    for (int i = 0; i < 8; i++) begin
      run_one(tbl[i].req, tbl[i].exp_idx);
      @(negedge clk);
    end

    // full contention: order 0,1,2,0 spaced BC+2 cycles apart
    do_reset();
    for (int g = 0; g < 4; g++) begin
      exp_gnt_q.push_back(N'(1) << (g % N));
      exp_done_q.push_back(N'(1) << (g % N));
    end
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_gnt("cont_gnt");
      t_g[g] = cyc;
    end
    req = '0;
    for (int g = 1; g < 4; g++) chk("gnt_spacing", 32'(t_g[g] - t_g[g-1]), 32'(BC + 2));
    @(negedge clk);
    wait_idle();
    @(negedge clk);

    // abort on 2nd BREW cycle of owner 0; pending 011 then goes to 1
    do_reset();
    exp_gnt_q.push_back(3'b001);
    exp_abort_q.push_back(IW'(0));
    exp_gnt_q.push_back(3'b010);
    exp_done_q.push_back(3'b010);
    req = 3'b001;
    wait_gnt("abort_gnt");
    req = 3'b011;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_coffee", 32'(coffee), 32'd0);
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_nodone", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    wait_gnt("post_abort_gnt");
    req = '0;
    @(negedge clk);
    wait_idle();
    @(negedge clk);

    // abort coincident with the last brew cycle (last=1, so 100 -> 2)
    exp_gnt_q.push_back(3'b100);
    exp_abort_q.push_back(IW'(2));
    req = 3'b100;
    wait_gnt("late_abort_gnt");
    req = '0;
    repeat (BC - 1) @(negedge clk);
    chk("late_coffee_on", 32'(coffee), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("late_aborted", 32'(aborted), 32'd1);
    chk("late_nodone", 32'(done), 32'd0);
    chk("late_coffee", 32'(coffee), 32'd0);
    @(negedge clk);
    chk("late_nodone2", 32'(done), 32'd0);

    // abort while idle does nothing
    abort = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_abort_aborted", 32'(aborted), 32'd0);
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_coffee", 32'(coffee), 32'd0);
    chk("idle_abort_owner", 32'(owner), 32'd2);
    abort = 1'b0;
    @(negedge clk);

    // reset mid-brew, then pointer restored: 110 -> 1
    do_reset();
    exp_gnt_q.push_back(3'b001);
    req = 3'b001;
    wait_gnt("mid_rst_gnt");
    req = '0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_coffee", 32'(coffee), 32'd0);
    chk("midrst_aborted", 32'(aborted), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd0);
    run_one(3'b110, 1);
    repeat (3) @(negedge clk);

    // randomized single-request rounds against a small round-robin model
    begin
      int last_m;
      last_m = 1;
      for (int k = 0; k < 6; k++) begin
        logic [N-1:0] r;
        int pick;
        r = N'($urandom_range(1, 7));
        pick = 0;
        for (int s = 1; s <= N; s++) begin
          if (r[(last_m + s) % N]) begin
            pick = (last_m + s) % N;
            break;
          end
        end
        run_one(r, pick);
        last_m = pick;
        @(negedge clk);
      end
    end

    chk("gnt_q_empty", 32'(exp_gnt_q.size()), 32'd0);
    chk("done_q_empty", 32'(exp_done_q.size()), 32'd0);
    chk("abort_q_empty", 32'(exp_abort_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
